// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter side bundle of the UART TX round-robin arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic                        tx_valid;
    logic                        tx_busy;
    logic [ID_W-1:0]             active_id;
    logic                        arb_busy;
    logic                        err;

    // Arbiter view: consumes requests and transmitter busy, drives grants and the launch
    modport slave (
        input  req, req_data, tx_busy,
        output gnt, tx_data, tx_valid, active_id, arb_busy, err
    );

    // Environment view: requesters plus transmitter
    modport master (
        output req, req_data, tx_busy,
        input  gnt, tx_data, tx_valid, active_id, arb_busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte requesters,
// with launch watchdog and programmable inter-frame idle gap.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned WDOG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]      wdog_q, wdog_d;
    logic [CNT_W-1:0]      gap_q, gap_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  found_c;
    logic [ID_W-1:0]       sel_c;
    logic [DATA_WIDTH-1:0] bytes_c [N_REQ];

    // Split the flat request data bus into per-requester bytes
    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign bytes_c[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending requester at or above the pointer, wrapping around
    always_comb begin
        int unsigned j;
        found_c = 1'b0;
        sel_c   = '0;
        j       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found_c && bus.req[ID_W'(j)]) begin
                found_c = 1'b1;
                sel_c   = ID_W'(j);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;
        gnt_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    data_d  = bytes_c[sel_c];
                    id_d    = sel_c;
                    gnt_d   = N_REQ'(1) << sel_c;
                    valid_d = 1'b1;
                    ptr_d   = (sel_c == ID_W'(N_REQ - 1)) ? '0 : sel_c + ID_W'(1);
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                    // Transmitter never acknowledged: drop the frame, no retry
                    if ((wdog_q + CNT_W'(1)) == CNT_W'(WDOG_CYCLES)) begin
                        err_d   = 1'b1;
                        gap_d   = CNT_W'(GAP_CYCLES);
                        state_d = S_GAP;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = CNT_W'(GAP_CYCLES);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q <= CNT_W'(1)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, pointer, counters and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
            gap_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_valid  = valid_q;
    assign bus.active_id = id_q;
    assign bus.arb_busy  = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized
// phase scored against a frame-level reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int G  = 2;
    localparam int WD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus_b ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(G), .WDOG_CYCLES(WD)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(0), .WDOG_CYCLES(WD)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stubs: busy for stub_len cycles starting the cycle after a launch
    int stub_a_len = 10;
    int stub_b_len = 3;
    bit stub_a_en  = 1'b1;
    int stub_a_cnt = 0;
    int stub_b_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst)                                stub_a_cnt <= 0;
        else if (stub_a_en && bus_a.tx_valid)   stub_a_cnt <= stub_a_len;
        else if (stub_a_cnt > 0)                stub_a_cnt <= stub_a_cnt - 1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst)                    stub_b_cnt <= 0;
        else if (bus_b.tx_valid)    stub_b_cnt <= stub_b_len;
        else if (stub_b_cnt > 0)    stub_b_cnt <= stub_b_cnt - 1;
    end
    assign bus_a.tx_busy = (stub_a_cnt > 0);
    assign bus_b.tx_busy = (stub_b_cnt > 0);

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int         ptr_m        = 0;
    logic [7:0] bytes_m [N];
    logic [7:0] last_data_a  = 8'h00;
    int         last_launch_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set bit at or after p, wrapping
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (m[j]) return j;
        end
        return 0;
    endfunction

    task automatic drive_a(input logic [3:0] m);
        bus_a.req      = m;
        bus_a.req_data = {bytes_m[3], bytes_m[2], bytes_m[1], bytes_m[0]};
    endtask

    // Wait for the next launch on DUT A and check it against the model
    task automatic expect_launch_a(input string tag, input int exp_id,
                                   input logic [7:0] exp_data, input int exp_cyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (bus_a.tx_valid === 1'b1) begin
                found = 1'b1;
            end else begin
                chk({tag, "_hold_data"}, 32'(bus_a.tx_data), 32'(last_data_a));
                chk({tag, "_hold_gnt"}, 32'(bus_a.gnt), 32'(0));
            end
        end
        chk({tag, "_seen"}, 32'(found), 32'(1));
        if (found) begin
            chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, "_gnt"}, 32'(bus_a.gnt), 32'(1) << exp_id);
            chk({tag, "_data"}, 32'(bus_a.tx_data), 32'(exp_data));
            chk({tag, "_id"}, 32'(bus_a.active_id), 32'(exp_id));
            chk({tag, "_arb_busy"}, 32'(bus_a.arb_busy), 32'(1));
            last_data_a   = exp_data;
            last_launch_a = cyc;
            ptr_m         = (exp_id + 1) % N;
        end
    endtask

    task automatic wait_idle_a(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (bus_a.arb_busy === 1'b0) found = 1'b1;
        end
        chk({tag, "_idle"}, 32'(found), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int L;
        int t;
        int len;
        int id;
        logic [3:0] mask;
        bit found;

        rst            = 1'b1;
        bytes_m        = '{8'h00, 8'h00, 8'h00, 8'h00};
        drive_a(4'b0000);
        bus_b.req      = '0;
        bus_b.req_data = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_gnt", 32'(bus_a.gnt), 32'(0));
        chk("rst_tx_data", 32'(bus_a.tx_data), 32'(0));
        chk("rst_tx_valid", 32'(bus_a.tx_valid), 32'(0));
        chk("rst_active_id", 32'(bus_a.active_id), 32'(0));
        chk("rst_arb_busy", 32'(bus_a.arb_busy), 32'(0));
        chk("rst_err", 32'(bus_a.err), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single request, held so it is re-granted after the gap; data changed mid-frame
        bytes_m[0] = 8'hA5;
        drive_a(4'b0001);
        t = cyc;
        expect_launch_a("single", 0, 8'hA5, t + 1);
        L = last_launch_a;
        bytes_m[0] = 8'h5A;
        drive_a(4'b0001);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("single_no_valid", 32'(bus_a.tx_valid), 32'(0));
            chk("single_data_held", 32'(bus_a.tx_data), 32'(8'hA5));
            chk("single_arb_busy", 32'(bus_a.arb_busy), (cyc == L + 14) ? 32'(0) : 32'(1));
        end
        expect_launch_a("single_regrant", 0, 8'h5A, L + 10 + G + 3);
        drive_a(4'b0000);
        wait_idle_a("single");

        // Watchdog: transmitter never goes busy
        stub_a_en  = 1'b0;
        bytes_m[1] = 8'h3C;
        drive_a(4'b0010);
        t = cyc;
        expect_launch_a("wdog", 1, 8'h3C, t + 1);
        L = last_launch_a;
        for (int c = 1; c <= WD + 1; c++) begin
            @(negedge clk);
            chk("wdog_err", 32'(bus_a.err), (cyc == L + WD + 1) ? 32'(1) : 32'(0));
        end
        stub_a_en  = 1'b1;
        stub_a_len = 4;
        expect_launch_a("wdog_regrant", 1, 8'h3C, L + WD + G + 2);
        drive_a(4'b0000);
        wait_idle_a("wdog");

        // Reset asserted during WAIT_DONE
        stub_a_len = 10;
        bytes_m[3] = 8'hE7;
        drive_a(4'b1000);
        expect_launch_a("pre_reset", 3, 8'hE7, cyc + 1);
        drive_a(4'b0000);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus_a.gnt), 32'(0));
        chk("mid_rst_tx_data", 32'(bus_a.tx_data), 32'(0));
        chk("mid_rst_tx_valid", 32'(bus_a.tx_valid), 32'(0));
        chk("mid_rst_active_id", 32'(bus_a.active_id), 32'(0));
        chk("mid_rst_arb_busy", 32'(bus_a.arb_busy), 32'(0));
        chk("mid_rst_err", 32'(bus_a.err), 32'(0));
        ptr_m       = 0;
        last_data_a = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // Round-robin fairness from pointer 0 with all four requesting
        bytes_m    = '{8'h10, 8'h21, 8'h32, 8'h43};
        stub_a_len = 2;
        drive_a(4'b1111);
        t = cyc;
        expect_launch_a("rr0", 0, 8'h10, t + 1);
        expect_launch_a("rr1", 1, 8'h21, last_launch_a + 2 + G + 3);
        expect_launch_a("rr2", 2, 8'h32, last_launch_a + 2 + G + 3);
        expect_launch_a("rr3", 3, 8'h43, last_launch_a + 2 + G + 3);
        expect_launch_a("rr4", 0, 8'h10, last_launch_a + 2 + G + 3);
        drive_a(4'b0000);
        wait_idle_a("rr");

        // Wrap and skip: grant 2 leaves pointer at 3, then 0101 grants 0 then 2
        drive_a(4'b0100);
        expect_launch_a("wrap_a", 2, 8'h32, cyc + 1);
        drive_a(4'b0101);
        expect_launch_a("wrap_b", 0, 8'h10, last_launch_a + 2 + G + 3);
        expect_launch_a("wrap_c", 2, 8'h32, last_launch_a + 2 + G + 3);
        drive_a(4'b0000);
        wait_idle_a("wrap");

        // Randomized masks, bytes and frame lengths against the model
        mask = 4'($urandom_range(1, 15));
        for (int k = 0; k < N; k++) bytes_m[k] = 8'($urandom);
        len = $urandom_range(1, 6);
        stub_a_len = len;
        drive_a(mask);
        t = cyc + 1;
        for (int f = 0; f < 20; f++) begin
            id = pick(mask, ptr_m);
            expect_launch_a("rand", id, bytes_m[id], t);
            len  = $urandom_range(1, 6);
            stub_a_len = len;
            t    = last_launch_a + len + G + 3;
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) bytes_m[k] = 8'($urandom);
            drive_a(mask);
        end
        drive_a(4'b0000);
        wait_idle_a("rand");

        // Zero gap on the second instance: next launch two cycles after busy falls
        bus_b.req      = 4'b0001;
        bus_b.req_data = {8'h00, 8'h00, 8'h00, 8'h77};
        found = 1'b0;
        L = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (bus_b.tx_valid === 1'b1) begin
                found = 1'b1;
                L = cyc;
            end
        end
        chk("zgap_first_seen", 32'(found), 32'(1));
        chk("zgap_first_gnt", 32'(bus_b.gnt), 32'(1));
        chk("zgap_first_data", 32'(bus_b.tx_data), 32'(8'h77));
        for (int c = 1; c <= stub_b_len + 3; c++) begin
            @(negedge clk);
            chk("zgap_valid", 32'(bus_b.tx_valid), (cyc == L + stub_b_len + 3) ? 32'(1) : 32'(0));
            chk("zgap_arb_busy", 32'(bus_b.arb_busy), (cyc == L + stub_b_len + 2) ? 32'(0) : 32'(1));
        end
        chk("zgap_second_gnt", 32'(bus_b.gnt), 32'(1));
        bus_b.req = 4'b0000;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between N byte requesters. It accepts level requests, launches one frame at a time by pulsing the transmitter's valid input, and tracks the frame through the transmitter's busy flag. It enforces a programmable idle gap between frames and sits directly in front of the transmitter (serializer, parity, mux, FSM).

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- DATA_WIDTH, 8: byte width per requester.
- GAP_CYCLES, 2: idle cycles inserted after TX_BUSY falls before the next launch, 0..15.
- WDOG_CYCLES, 4: cycles allowed for TX_BUSY to rise after launch, 2..15.

Ports:
- CLK, in, 1: single clock, rising edge.
- RST, in, 1: asynchronous, active-high reset.
- REQ, in, N_REQ: level request per requester; bit i high means requester i has a byte pending.
- REQ_DATA, in, N_REQ*DATA_WIDTH: byte of requester i on bits [i*DATA_WIDTH +: DATA_WIDTH].
- GNT, out, N_REQ: one-hot, one-cycle pulse; the byte of requester i has been captured.
- TX_DATA, out, DATA_WIDTH: byte to the transmitter, held stable from launch until the frame ends.
- TX_VALID, out, 1: one-cycle launch pulse to the transmitter.
- TX_BUSY, in, 1: busy from the transmitter.
- ACTIVE_ID, out, clog2(N_REQ) (min 1): index of the requester owning the current frame.
- ARB_BUSY, out, 1: high in every state except IDLE.
- ERR, out, 1: one-cycle pulse on watchdog expiry.

## Operation
- All outputs are registered. Reset values: GNT=0, TX_DATA=0, TX_VALID=0, ACTIVE_ID=0, ARB_BUSY=0, ERR=0. State resets to IDLE, the round-robin pointer to 0, and both counters to 0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if REQ≠0, select the first set bit searching from the pointer upward with wrap-around. Capture its byte into TX_DATA and set ACTIVE_ID. Pulse GNT[i] and TX_VALID. Set pointer=(i+1) mod N_REQ. Go to LAUNCH.
- LAUNCH: TX_VALID and GNT return to 0. Clear the watchdog counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1: go to WAIT_DONE.
  - Otherwise increment the watchdog. When it reaches WDOG_CYCLES, pulse ERR and go to GAP. The pointer is already advanced and the frame is dropped, with no retry.
- WAIT_DONE: stay while TX_BUSY=1. On TX_BUSY=0, load the gap counter with GAP_CYCLES and go to GAP. If GAP_CYCLES=0, go straight to IDLE.
- GAP: decrement each cycle and go to IDLE when the count reaches 0. REQ is ignored outside IDLE.
- Requests are level-sensitive, and one GNT consumes one byte. A requester that holds REQ high after its GNT is treated as having another byte pending. It is re-arbitrated fairly, after all other pending requesters.
- REQ_DATA is sampled only in the IDLE cycle that grants. Changes at any other time have no effect.
- Reset asserted mid-frame returns every output to its reset value immediately. It does not wait for TX_BUSY. Frames in flight in the transmitter are not tracked after reset.

## Timing
- Cycle T: IDLE sees REQ≠0.
- T+1: GNT and TX_VALID high, TX_DATA valid, state LAUNCH.
- T+2: the transmitter is expected to show TX_BUSY=1 (it registers the valid pulse).
- Watchdog expiry: ERR is high in cycle T+2+WDOG_CYCLES when TX_BUSY never rises.
- TX_BUSY falls in cycle F:
  - GAP_CYCLES=0: earliest next TX_VALID is F+2.
  - GAP_CYCLES=G>0: earliest next TX_VALID is F+G+2.
- ARB_BUSY is high from T+1 until the cycle the state returns to IDLE.
- Only one GNT is asserted at a time. At most one launch is in flight.

## Test plan
- Single request: N_REQ=4, REQ=0001, REQ_DATA[7:0]=0xA5, stub busy high for 10 cycles starting 1 cycle after TX_VALID. Expect: GNT=0001 and TX_VALID at T+1, TX_DATA=0xA5 held through the frame, next launch possible no earlier than F+4 with GAP=2.
- Round-robin fairness: REQ=1111 held, bytes 0x10/0x21/0x32/0x43. Expect grant order 0,1,2,3,0 and TX_DATA sequence 0x10,0x21,0x32,0x43,0x10.
- Wrap and skip: pointer=3 after a grant to 2, REQ=0101. Expect a grant to 0, then 2, with ACTIVE_ID matching each grant.
- Watchdog: TX_BUSY tied 0, REQ=0010. Expect GNT=0010, ERR pulse at T+6 (WDOG=4), then GAP, and REQ re-granted after the gap because it is still high.
- Reset mid-frame: assert RST during WAIT_DONE. Expect all outputs 0 asynchronously, IDLE after release, and the first grant from pointer 0.
- Zero gap: GAP_CYCLES=0, busy falls at F, REQ pending. Expect the next TX_VALID at F+2 and no GAP state visited.
